// File: rtl/freq_avg_buffer.sv
// Sliding-window mean over the last 2**DEPTH_LOG2 frequency samples of a measurement run.
// Optional FREQ_AVG_MINMAX_EN adds per-run min_freq/max_freq tracking outputs.
module freq_avg_buffer #(
   parameter int WIDTH      = 13,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  start,
   input  logic [15:0]           samples_required,
   input  logic                  sample_valid,
   input  logic [WIDTH-1:0]      sample,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [WIDTH-1:0]      rd_data,
   output logic [WIDTH-1:0]      average,
   output logic                  avg_valid,
   output logic                  window_full,
   output logic                  busy,
   output logic                  done
`ifdef FREQ_AVG_MINMAX_EN
   ,
   output logic [WIDTH-1:0]      min_freq,
   output logic [WIDTH-1:0]      max_freq
`endif
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int SUM_W = WIDTH + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [WIDTH-1:0]    window [DEPTH];
   logic [SUM_W-1:0]    sum;
   logic [SUM_W-1:0]    sum_next;
   logic [DEPTH_LOG2:0] fill_count;
   logic [15:0]         sample_count;
   logic [15:0]         req_count;

   assign rd_data     = window[rd_idx];
   assign window_full = (fill_count == FULL_COUNT);

   // The oldest entry is always part of sum, so subtracting it never underflows.
   always_comb begin
      sum_next = sum + SUM_W'(sample) - SUM_W'(window[DEPTH-1]);
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state        <= IDLE;
         for (int i = 0; i < DEPTH; i++) window[i] <= '0;
         sum          <= '0;
         fill_count   <= '0;
         sample_count <= '0;
         req_count    <= '0;
         average      <= '0;
         avg_valid    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef FREQ_AVG_MINMAX_EN
         min_freq     <= '0;
         max_freq     <= '0;
`endif
      end else begin
         avg_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= RUN;
                  busy         <= 1'b1;
                  for (int i = 0; i < DEPTH; i++) window[i] <= '0;
                  sum          <= '0;
                  fill_count   <= '0;
                  sample_count <= '0;
                  req_count    <= samples_required;
`ifdef FREQ_AVG_MINMAX_EN
                  min_freq     <= '1;
                  max_freq     <= '0;
`endif
               end
            end
            RUN: begin
               // A zero-length run finishes without looking at sample_valid.
               if (req_count == 16'd0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (sample_valid) begin
                  for (int i = DEPTH - 1; i > 0; i--) window[i] <= window[i-1];
                  window[0]    <= sample;
                  sum          <= sum_next;
                  average      <= sum_next[SUM_W-1:DEPTH_LOG2];
                  avg_valid    <= 1'b1;
                  sample_count <= sample_count + 16'd1;
                  if (!window_full) fill_count <= fill_count + 1'b1;
`ifdef FREQ_AVG_MINMAX_EN
                  if (sample < min_freq) min_freq <= sample;
                  if (sample > max_freq) max_freq <= sample;
`endif
                  if (sample_count + 16'd1 == req_count) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/freq_avg_buffer.md
FREQ_AVG_BUFFER -- requirements
Module: freq_avg_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of window depth (DEPTH = 2**DEPTH_LOG2, legal range 1..6).
REQ-003 The block SHALL have these ports:
  Clock  input  1  system clock; all state changes on its rising edge.
  nReset  input  1  reset, asynchronous, active-low.
  start  input  1  single-cycle request to begin a measurement run.
  samples_required  input  16  number of samples to accept per run.
  sample_valid  input  1  single-cycle strobe qualifying sample.
  sample  input  WIDTH  frequency count from the counter.
  rd_idx  input  DEPTH_LOG2  window read index; 0 = newest.
  rd_data  output  WIDTH  combinational window entry at rd_idx.
  average  output  WIDTH  registered window mean.
  avg_valid  output  1  one-cycle pulse when average updates.
  window_full  output  1  high once DEPTH samples are held in the current run.
  busy  output  1  high in RUN.
  done  output  1  one-cycle pulse at end of run.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
REQ-005 IDLE -> RUN SHALL occur on start=1; in the same edge, all window entries, the running sum, the fill count and the sample count SHALL clear to 0.
REQ-006 start SHALL be ignored in RUN and DONE.
REQ-007 In RUN, sample_valid=1 SHALL accept sample: the window shifts by one (oldest discarded), sample enters entry 0, and the sample count increments.
REQ-008 sample_valid SHALL be ignored in IDLE and DONE.
REQ-009 The running sum SHALL be WIDTH+DEPTH_LOG2 bits wide, SHALL update as sum + sample - oldest entry, and SHALL never overflow or wrap.
REQ-010 average SHALL be registered on the acceptance edge as (new sum) >> DEPTH_LOG2 (truncating); empty entries count as 0.
REQ-011 avg_valid SHALL be high for exactly the cycle after each acceptance.
REQ-012 The fill count SHALL saturate at DEPTH; window_full SHALL equal (fill count == DEPTH).
REQ-013 RUN -> DONE SHALL occur on the edge where the accepted sample makes the sample count equal samples_required.
REQ-014 If samples_required = 0 at start, RUN -> DONE SHALL occur on the first RUN edge with no sample accepted.
REQ-015 DONE -> IDLE SHALL occur unconditionally after one cycle; done SHALL be high only in DONE.
REQ-016 The window contents and average SHALL hold their values in DONE and IDLE until the next start.
REQ-017 busy SHALL be 1 exactly in RUN.
REQ-018 The block SHALL sample samples_required only on the IDLE -> RUN edge; later changes SHALL have no effect on the current run.

Reset
REQ-019 nReset=0 SHALL immediately force state IDLE and clear all window entries, sum, counts, average, avg_valid, window_full, done and busy to 0, including in the middle of a run.
REQ-020 After nReset is released, the block SHALL require a new start before accepting samples.

Configuration
REQ-021 With macro FREQ_AVG_MINMAX_EN defined, the block SHALL add outputs min_freq and max_freq (WIDTH bits each, registered).
REQ-022 min_freq and max_freq SHALL track the extremes of all samples accepted in the current run.
REQ-023 On start, min_freq SHALL be set to all-ones and max_freq SHALL be set to 0.
REQ-024 On reset, min_freq and max_freq SHALL both be set to 0.
REQ-025 Without FREQ_AVG_MINMAX_EN, these outputs and their logic SHALL be absent.

Verification
REQ-026 Scenario: defaults, samples_required=8, start, then samples 8,16,24,...,64 -> averages 1,3,6,10,15,21,28,36; window_full rises with the 8th avg_valid; done pulses one cycle after the 8th sample.
REQ-027 Scenario: samples_required=12 with constant sample 100 -> average is 100 from the 8th sample on; rd_data for every rd_idx is 100; done pulses after the 12th sample.
REQ-028 Scenario: samples_required=0, start -> done one cycle after RUN entry, with no avg_valid pulse.
REQ-029 Scenario: WIDTH=13 with eight samples of 8191 -> average 8191 with no overflow; a 9th sample of 0 -> average 7167.
REQ-030 Scenario: nReset asserted after 3 of 8 samples -> all outputs 0 immediately; later sample_valid pulses without start are ignored.
REQ-031 Scenario: with FREQ_AVG_MINMAX_EN, samples 50,20,90 -> min_freq 20 and max_freq 90; a second start re-initialises min_freq to 8191 and max_freq to 0.
